// File: rtl/instr_encoder.sv
// MIPS subset instruction encoder / program loader: encodes fields and writes words sequentially.
// Optional macro ENC_CHECK_EN: illegal op_sel is consumed without a write and sets sticky err.
module instr_encoder #(
  parameter int AW        = 8,
  parameter int DEPTH     = 256,
  parameter int BASE_ADDR = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          stop,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    op_sel,
  input  logic [4:0]    rs,
  input  logic [4:0]    rt,
  input  logic [4:0]    rd,
  input  logic [15:0]   imm,
  output logic          mem_we,
  input  logic          mem_ready,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic [AW:0]   count,
  output logic          full,
  output logic          done,
  output logic          err
);

  // state | meaning
  // IDLE  | not loading, inputs ignored
  // RUN   | accepting fields, writing words
  // DRAIN | stop seen, finishing pending write
  // FULL  | DEPTH words written, input blocked
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FULL} state_t;

  localparam logic [AW:0]   LAST_CNT = (AW+1)'(DEPTH - 1);
  localparam logic [AW-1:0] BASE     = AW'(BASE_ADDR);

  state_t      state, state_nxt;
  logic        restart;
  logic        done_nxt;
  logic        wr_done;
  logic        last_wr;
  logic        accept;
  logic        write_word;
  logic [31:0] enc;

  assign wr_done = mem_we && mem_ready;
  assign last_wr = (count == LAST_CNT) && !restart;
  assign accept  = in_valid && in_ready;

`ifdef ENC_CHECK_EN
  logic op_legal;
  assign op_legal   = (op_sel <= 4'd8);
  assign write_word = op_legal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   err <= 1'b0;
    else if (start)               err <= 1'b0;
    else if (accept && !op_legal) err <= 1'b1;
  end
`else
  assign write_word = 1'b1;
  assign err        = 1'b0;
`endif

  always_comb begin
    enc = 32'h0;
    case (op_sel)
      4'd0: enc = {6'b000000, rs, rt, rd, 5'b0, 6'b100000};
      4'd1: enc = {6'b000000, rs, rt, rd, 5'b0, 6'b100010};
      4'd2: enc = {6'b000000, rs, rt, rd, 5'b0, 6'b100100};
      4'd3: enc = {6'b000000, rs, rt, rd, 5'b0, 6'b100101};
      4'd4: enc = {6'b000000, rs, rt, rd, 5'b0, 6'b101010};
      4'd5: enc = {6'b100011, rs, rt, imm};
      4'd6: enc = {6'b101011, rs, rt, imm};
      4'd7: enc = {6'b000100, rs, rt, imm};
      4'd8: enc = {6'b001000, rs, rt, imm};
      default: enc = 32'h0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = RUN;
      RUN: begin
        if (start)                   state_nxt = RUN;
        else if (stop)               state_nxt = DRAIN;
        else if (wr_done && last_wr) state_nxt = FULL;
      end
      DRAIN: begin
        if (start)        state_nxt = RUN;
        else if (!mem_we) state_nxt = IDLE;
      end
      FULL: begin
        if (start)     state_nxt = RUN;
        else if (stop) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The last-slot guard keeps a DEPTH+1'th word from being accepted behind the final write.
  always_comb begin
    in_ready = (state == RUN) && (!mem_we || (mem_ready && !last_wr));
    done_nxt = !start && (((state == DRAIN) && !mem_we) || ((state == FULL) && stop));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we    <= 1'b0;
      mem_wdata <= 32'h0;
      mem_addr  <= BASE;
      count     <= '0;
      full      <= 1'b0;
      done      <= 1'b0;
      restart   <= 1'b0;
    end else begin
      done <= done_nxt;

      if (accept && write_word) begin
        mem_we    <= 1'b1;
        mem_wdata <= enc;
      end else if (wr_done) begin
        mem_we <= 1'b0;
      end

      // A start during a stalled write lets it finish at its old address first.
      if (wr_done) begin
        if (restart || start) begin
          mem_addr <= BASE;
          count    <= '0;
          restart  <= 1'b0;
        end else begin
          count <= count + 1'b1;
          if (!last_wr) mem_addr <= mem_addr + 1'b1;
        end
      end else if (start) begin
        count <= '0;
        if (mem_we) restart  <= 1'b1;
        else        mem_addr <= BASE;
      end

      if (start)                    full <= 1'b0;
      else if (wr_done && last_wr)  full <= 1'b1;
    end
  end

endmodule
